dmem_loader: RTL
================

Name: dmem_loader

Overview:
- Writer-side front end for the single-cycle MIPS core (`mips_cpu`).
- Holds the CPU in reset while it streams input operands (e.g. patient temperature words) into data memory over a valid/ready stream.
- Then releases the CPU for a fixed cycle budget and re-asserts hold, leaving the program's result word (e.g. data_memory[3]) stable for readout.
- Sits beside `mips_cpu`; its dm_* outputs feed the data-memory write port through a top-level mux selected by cpu_hold.

Parameters:
- BASE_ADDR, 0: byte address of the first word written; must be word aligned.
- NUM_WORDS, 3: number of input words per load, range 1..255.
- RUN_CYCLES, 32: clock cycles the CPU runs after the load, range 1..65535.

Ports:
- clock  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse that begins a load; honoured only in IDLE or DONE.
- s_valid  in  1  stream data valid.
- s_ready  out  1  loader accepts a beat.
- s_data  in  32  input word.
- s_last  in  1  marks the final beat of a load.
- dm_we  out  1  data-memory write enable.
- dm_addr  out  32  data-memory byte address.
- dm_wdata  out  32  data-memory write data.
- cpu_hold  out  1  1 = keep `mips_cpu` in reset and give the loader the memory port.
- busy  out  1  high in LOAD or RUN.
- done  out  1  high in DONE.
- err  out  1  sticky framing error for the current load.

Behaviour:
- Reset (reset=0, asynchronous):
  - State = IDLE, word index = 0, run counter = 0.
  - Outputs: s_ready=0, dm_we=0, dm_addr=0, dm_wdata=0, cpu_hold=1, busy=0, done=0, err=0.
- Reset asserted mid-LOAD or mid-RUN aborts immediately to these values. Partially written memory is not cleared.
- All outputs are registered.
- States: IDLE, LOAD, RUN, DONE.
- IDLE:
  - cpu_hold=1, s_ready=0.
  - start=1 -> LOAD; index cleared, err cleared.
- LOAD:
  - s_ready=1, cpu_hold=1, busy=1.
  - A beat is accepted on s_valid & s_ready.
  - The cycle after an accepted beat: dm_we=1, dm_addr=BASE_ADDR+4*index, dm_wdata=s_data of that beat. Index then increments.
  - dm_we=0 in any cycle following a non-accepting cycle.
- LOAD exit:
  - Leave after the beat that is the NUM_WORDS-th or carries s_last, whichever comes first.
  - s_ready drops to 0 in the cycle after that final accept.
- Framing error: err=1 if s_last arrives before beat NUM_WORDS, or if beat NUM_WORDS arrives without s_last. The load still ends as above.
- Write completion: the final dm_we pulse is issued in the first RUN cycle, with cpu_hold still 1 in that cycle.
- RUN:
  - cpu_hold=0 starting the cycle after the final write.
  - Counter loads RUN_CYCLES and decrements each cycle.
  - When the counter reaches 0: cpu_hold=1, go to DONE.
  - The CPU therefore runs exactly RUN_CYCLES rising edges.
- Ignored inputs: start is ignored in LOAD and RUN; s_valid is ignored outside LOAD.
- DONE:
  - done=1, cpu_hold=1, busy=0; err holds its value.
  - start=1 -> LOAD; done cleared, err cleared, index=0.
- Simultaneous s_valid and start in IDLE: start is consumed; s_ready rises the next cycle, so no beat is accepted in the start cycle.
- Address width: the index is 8 bits; dm_addr is BASE_ADDR + {index,2'b00} zero-extended to 32 bits, with no wrap inside range.

Decomposition:
- Shared package `mips_pkg` holds:
  - state encoding localparams S_IDLE=2'd0, S_LOAD=2'd1, S_RUN=2'd2, S_DONE=2'd3;
  - WORD_BYTES=4;
  - RESULT_WORD_IDX=3, the result cell read by benches.
- One sub-module, `cycle_down_counter`: 16-bit, load/enable/zero flag. It is used for the RUN budget.
- The memory-port mux stays in the top level, not in this block.

Test Plan:
- Reset: hold reset=0 for 2 cycles -> cpu_hold=1, s_ready=0, dm_we=0, done=0, err=0; release, no start -> remains IDLE.
- Nominal load (BASE_ADDR=0, NUM_WORDS=3): start, then beats 36, 38, 1 with s_last on the third -> dm_we pulses at addresses 0, 4, 8 with data 36, 38, 1; err=0; cpu_hold=0 for exactly 32 cycles; then done=1.
- Backpressure gaps: s_valid toggled 1,0,0,1,0,1 -> exactly 3 writes, none duplicated, addresses strictly 0, 4, 8.
- Short frame: s_last on beat 2 -> err=1; only 2 writes; RUN still entered; done=1 with err=1 held.
- Missing s_last on beat 3 -> err=1; load ends after 3 writes; a fourth s_valid beat is not accepted (s_ready=0).
- Reset asserted at RUN cycle 10 -> cpu_hold=1 immediately (asynchronous); state IDLE; a subsequent start performs a clean reload with err=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the mips_cpu front-end blocks: loader state
// encoding, memory geometry and the address helper used by the loader.
package mips_pkg;

  // Loader FSM encoding
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // Data memory geometry
  localparam int WORD_BYTES      = 4;
  // Data-memory word holding the program's result
  localparam int RESULT_WORD_IDX = 3;

  // Byte address of word 'idx' relative to 'base'. The index is zero-extended
  // and shifted by two, so 8-bit indices never wrap inside the 32-bit space.
  function automatic logic [31:0] word_addr(input logic [31:0] base,
                                            input logic [7:0]  idx);
    return base + {22'd0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/cycle_down_counter.sv
// Loadable down counter with a zero flag. It saturates at zero, so holding
// en_i high after expiry is harmless.
module cycle_down_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic [W-1:0] count_o,
  output logic         zero_o
);

  logic [W-1:0] count_q;

  // Load takes priority over decrement; decrement stops at zero
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (en_i && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign count_o = count_q;
  assign zero_o  = (count_q == '0);

endmodule

// File: rtl/dmem_loader.sv
// Writer-side front end for mips_cpu: holds the CPU in reset while a
// valid/ready stream is copied into data memory, then releases the CPU for
// a fixed number of cycles and re-asserts hold so the result stays stable.
//
// Stream handshake: a beat transfers on a rising edge where s_valid and
// s_ready are both 1. s_ready is a registered output, high only in LOAD;
// s_data/s_last are meaningful only while s_valid is 1, and s_valid is
// ignored whenever s_ready is 0.
module dmem_loader
  import mips_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'd0,
  parameter int          NUM_WORDS  = 3,
  parameter int          RUN_CYCLES = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_data,
  input  logic        s_last,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [7:0]  LAST_IDX = 8'(NUM_WORDS - 1);
  localparam logic [15:0] RUN_LOAD = 16'(RUN_CYCLES);

  logic [1:0]  state_q, state_d;
  logic [7:0]  idx_q, idx_d;
  logic        s_ready_q, s_ready_d;
  logic        dm_we_q, dm_we_d;
  logic [31:0] dm_addr_q, dm_addr_d;
  logic [31:0] dm_wdata_q, dm_wdata_d;
  logic        cpu_hold_q, cpu_hold_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        accept;
  logic        last_beat;
  logic        start_ok;
  logic        at_last_idx;
  logic        cnt_zero;
  logic [15:0] cnt_value;

  assign start_ok    = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign accept      = (state_q == S_LOAD) && s_valid && s_ready_q;
  assign at_last_idx = (idx_q == LAST_IDX);
  // The load ends on the NUM_WORDS-th beat or on s_last, whichever is first
  assign last_beat   = accept && (s_last || at_last_idx);

  // RUN budget: loaded on the final accept, counts down through RUN
  cycle_down_counter #(.W(16)) u_run_cnt (
    .clk_i      (clock),
    .rst_ni     (reset),
    .load_i     (last_beat),
    .load_val_i (RUN_LOAD),
    .en_i       (state_q == S_RUN),
    .count_o    (cnt_value),
    .zero_o     (cnt_zero)
  );

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_ok)  state_d = S_LOAD;
      S_LOAD:  if (last_beat) state_d = S_RUN;
      S_RUN:   if (cnt_zero)  state_d = S_DONE;
      S_DONE:  if (start_ok)  state_d = S_LOAD;
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values; every output is registered from these
  always_comb begin
    s_ready_d  = (state_d == S_LOAD);
    busy_d     = (state_d == S_LOAD) || (state_d == S_RUN);
    done_d     = (state_d == S_DONE);
    // Hold stays high through the first RUN cycle so the last write lands
    // while the loader still owns the memory port.
    cpu_hold_d = !((state_q == S_RUN) && (state_d == S_RUN));
    dm_we_d    = accept;
    dm_addr_d  = accept ? word_addr(BASE_ADDR, idx_q) : dm_addr_q;
    dm_wdata_d = accept ? s_data : dm_wdata_q;

    idx_d = idx_q;
    if (start_ok) begin
      idx_d = 8'd0;
    end else if (accept) begin
      idx_d = idx_q + 8'd1;
    end

    // Framing error: s_last early, or the final word without s_last
    err_d = err_q;
    if (start_ok) begin
      err_d = 1'b0;
    end else if (accept && (s_last != at_last_idx)) begin
      err_d = 1'b1;
    end
  end

  // Registered outputs and word index
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      idx_q      <= 8'd0;
      s_ready_q  <= 1'b0;
      dm_we_q    <= 1'b0;
      dm_addr_q  <= 32'd0;
      dm_wdata_q <= 32'd0;
      cpu_hold_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      idx_q      <= idx_d;
      s_ready_q  <= s_ready_d;
      dm_we_q    <= dm_we_d;
      dm_addr_q  <= dm_addr_d;
      dm_wdata_q <= dm_wdata_d;
      cpu_hold_q <= cpu_hold_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign s_ready  = s_ready_q;
  assign dm_we    = dm_we_q;
  assign dm_addr  = dm_addr_q;
  assign dm_wdata = dm_wdata_q;
  assign cpu_hold = cpu_hold_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule
